// File: rtl/uart_pkg.sv
// Shared types, widths and the parity helper for the UART transmit serializer.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_DIV_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Even parity is the XOR of the data bits; odd sense inverts it.
  function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO-side handshake of the UART transmit serializer: enable, show-ahead head and pop strobe.
interface uart_tx_serializer_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
);

  logic              tx_en_i;
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_data_i;
  logic              fifo_rd_o;

  modport master (
    output tx_en_i,
    output fifo_empty_i,
    output fifo_data_i,
    input  fifo_rd_o
  );

  modport slave (
    input  tx_en_i,
    input  fifo_empty_i,
    input  fifo_data_i,
    output fifo_rd_o
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Per-bit down-counter: bit_end marks the last clock of each bit, then reloads from the latched divisor.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] start_div,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt_r;

  assign bit_end = run && (cnt_r == '0);

  // Count down through each bit; a frame start preloads from the divisor being latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (start) begin
      cnt_r <= start_div - DIV_W'(1);
    end else if (bit_end) begin
      cnt_r <= div - DIV_W'(1);
    end else if (run) begin
      cnt_r <= cnt_r - DIV_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit back end: pops the FIFO and sends start, 8 data bits LSB-first, optional parity, 1/2 stops.
// Parity stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DIV_W  = UART_DIV_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  uart_tx_serializer_if.slave  fifo,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic                 stop2_i,
  input  logic                 parity_odd_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_tx_o
);

  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  logic [2:0]        state_r, state_n;
  logic [DATA_W-1:0] shift_r, shift_n;
  logic [IDX_W-1:0]  idx_r, idx_n;
  logic              second_r, second_n;
  logic              tx_r, tx_n;
  logic              busy_r, busy_n;
  logic              done_r, done_n;
  logic              ready_r, stop2_r, parity_r;
  logic [DIV_W-1:0]  div_r, div_eff_s;
  logic              pop_s, bit_end_s, par_s;

`ifdef UART_TX_PARITY_EN
  localparam logic HAS_PARITY = 1'b1;
  assign par_s = parity_bit(fifo.fifo_data_i, parity_odd_i);
`else
  localparam logic HAS_PARITY = 1'b0;
  logic unused_parity_s;
  assign unused_parity_s = parity_odd_i;
  assign par_s           = 1'b0;
`endif

  // ready_r keeps the pop strobe low while reset is held and for the first clock after it.
  assign pop_s     = ready_r && (state_r == ST_IDLE) && fifo.tx_en_i && !fifo.fifo_empty_i;
  assign div_eff_s = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;

  assign fifo.fifo_rd_o = pop_s;
  assign tx_o           = tx_r;
  assign busy_o         = busy_r;
  assign done_tx_o      = done_r;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .start     (pop_s),
    .run       (busy_r),
    .start_div (div_eff_s),
    .div       (div_r),
    .bit_end   (bit_end_s)
  );

  // Frame sequencing: the next line level is registered together with the state.
  always_comb begin
    state_n  = state_r;
    shift_n  = shift_r;
    idx_n    = idx_r;
    second_n = second_r;
    tx_n     = tx_r;
    busy_n   = busy_r;
    done_n   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (pop_s) begin
          state_n  = ST_START;
          shift_n  = fifo.fifo_data_i;
          idx_n    = '0;
          second_n = 1'b0;
          tx_n     = 1'b0;
          busy_n   = 1'b1;
        end else begin
          busy_n = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_n = ST_DATA;
          tx_n    = shift_r[0];
          shift_n = shift_r >> 1;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          idx_n = idx_r + IDX_W'(1);
          if (idx_r == IDX_W'(DATA_W - 1)) begin
            if (HAS_PARITY) begin
              state_n = ST_PARITY;
              tx_n    = parity_r;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            tx_n    = shift_r[0];
            shift_n = shift_r >> 1;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        tx_n = 1'b1;
        if (bit_end_s) begin
          if (stop2_r && !second_r) begin
            second_n = 1'b1;
          end else begin
            state_n  = ST_IDLE;
            second_n = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, shifter and line registers; frame settings are frozen at the pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      shift_r  <= '0;
      idx_r    <= '0;
      second_r <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ready_r  <= 1'b0;
      div_r    <= '0;
      stop2_r  <= 1'b0;
      parity_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      shift_r  <= shift_n;
      idx_r    <= idx_n;
      second_r <= second_n;
      tx_r     <= tx_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
      ready_r  <= 1'b1;
      if (pop_s) begin
        div_r    <= div_eff_s;
        stop2_r  <= stop2_i;
        parity_r <= par_s;
      end else begin
        div_r    <= div_r;
        stop2_r  <= stop2_r;
        parity_r <= parity_r;
      end
    end
  end

endmodule
